// File: rtl/typer_pkg.sv
// Shared definitions for the TypeR control path: FSM states, ALU/funct codes
// and R-type instruction field layout.
package typer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOR = 3'd5;
  localparam logic [2:0] ALU_SLT = 3'd6;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [5:0] R_OPCODE = 6'b000000;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SH_LSB = 6;
  localparam int FN_LSB = 0;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } rtype_t;

  function automatic rtype_t split_rtype(input logic [31:0] w);
    rtype_t f;
    f.opcode = w[OP_LSB +: 6];
    f.rs     = w[RS_LSB +: 5];
    f.rt     = w[RT_LSB +: 5];
    f.rd     = w[RD_LSB +: 5];
    f.shamt  = w[SH_LSB +: 5];
    f.funct  = w[FN_LSB +: 6];
    return f;
  endfunction

endpackage

// File: rtl/typer_seq_ctrl_if.sv
// Instruction-memory fetch bus: req/addr from the sequencer, ack/rdata back
// from memory in the same cycle.
interface typer_seq_ctrl_if #(
  parameter int AW = 10
) ();
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/typer_funct_dec.sv
// Combinational funct -> alu_op mapper; o_legal flags the supported R-type
// functions. Shared with the TypeR datapath.
module typer_funct_dec
  import typer_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_op,
  output logic       o_legal
);

  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    o_alu_op = ALU_ADD;
    o_legal  = 1'b1;
    case (i_funct)
      F_ADD:   o_alu_op = ALU_ADD;
      F_SUB:   o_alu_op = ALU_SUB;
      F_AND:   o_alu_op = ALU_AND;
      F_OR:    o_alu_op = ALU_OR;
      F_XOR:   o_alu_op = ALU_XOR;
      F_NOR:   o_alu_op = ALU_NOR;
      F_SLT:   o_alu_op = ALU_SLT;
      default: o_legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/typer_seq_ctrl.sv
// Multi-cycle R-type sequencer: FETCH -> DECODE -> EXEC -> WB per instruction,
// with start/busy/halted/err control and a saturating retired counter.
module typer_seq_ctrl
  import typer_pkg::*;
#(
  parameter int            AW       = 10,
  parameter logic [AW-1:0] END_ADDR = 'h040,
  parameter int            TIMEOUT  = 16,
  parameter int            CW       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  typer_seq_ctrl_if.master    imem,
  output logic [4:0]          rf_ra1,
  output logic [4:0]          rf_ra2,
  output logic [4:0]          rf_wa,
  output logic                rf_we,
  output logic [2:0]          alu_op,
  output logic                busy,
  output logic                halted,
  output logic                err,
  output logic [CW-1:0]       instr_cnt
);

  localparam int            WW        = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  state_e        r_state;
  logic [AW-1:0] r_pc;
  logic [31:0]   r_instr;
  logic [CW-1:0] r_cnt;
  logic [WW-1:0] r_wait;
  logic          r_req;
  logic [4:0]    r_ra1, r_ra2, r_wa;
  logic [2:0]    r_alu_op;
  logic          r_we, r_busy, r_halted, r_err;

  rtype_t        w_f;
  logic [2:0]    w_alu_op;
  logic          w_legal;
  logic [AW-1:0] w_pc_next;

  assign w_f       = split_rtype(r_instr);
  assign w_pc_next = r_pc + AW'(4);

  typer_funct_dec u_funct_dec (
    .i_funct  (w_f.funct),
    .o_alu_op (w_alu_op),
    .o_legal  (w_legal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_instr  <= '0;
      r_cnt    <= '0;
      r_wait   <= '0;
      r_req    <= 1'b0;
      r_ra1    <= '0;
      r_ra2    <= '0;
      r_wa     <= '0;
      r_alu_op <= '0;
      r_we     <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking only, so every branch below reads pre-edge state.
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
            r_wait  <= '0;
          end
        end
        S_DONE: begin
          if (start) begin
            r_pc     <= '0;
            r_cnt    <= '0;
            r_halted <= 1'b0;
            r_state  <= S_FETCH;
            r_req    <= 1'b1;
            r_busy   <= 1'b1;
            r_wait   <= '0;
          end
        end
        S_FETCH: begin
          if (imem.imem_ack) begin
            r_instr <= imem.imem_rdata;
            r_req   <= 1'b0;
            r_state <= S_DECODE;
          end else if (r_wait == WAIT_LAST) begin
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_DECODE: begin
          r_ra1    <= w_f.rs;
          r_ra2    <= w_f.rt;
          r_wa     <= w_f.rd;
          r_alu_op <= w_alu_op;
          if (w_f.opcode != R_OPCODE || w_f.shamt != '0 || !w_legal) begin
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Writes to $0 are architecturally discarded, so no enable pulse.
          r_we    <= (r_wa != 5'd0);
          r_state <= S_WB;
        end
        S_WB: begin
          r_pc <= w_pc_next;
          if (!(&r_cnt)) r_cnt <= r_cnt + 1'b1;
          if (w_pc_next == END_ADDR) begin
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_req   <= 1'b1;
            r_wait  <= '0;
            r_state <= S_FETCH;
          end
        end
        S_ERR:   ;
        default: r_state <= S_ERR;
      endcase
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = (r_state == S_ERR) ? '0 : r_pc;
  assign rf_ra1         = r_ra1;
  assign rf_ra2         = r_ra2;
  assign rf_wa          = r_wa;
  assign rf_we          = r_we;
  assign alu_op         = r_alu_op;
  assign busy           = r_busy;
  assign halted         = r_halted;
  assign err            = r_err;
  assign instr_cnt      = r_cnt;

endmodule
